ffdiv_operand_decode: RTL and testbench
=======================================

# ffdiv_operand_decode

Front-end decoder for the FP32 fast divider. It accepts a dividend/divisor pair of IEEE-754 single-precision words over a valid/ready handshake and classifies each operand. It normalizes denormal significands iteratively, derives the special-case results, and presents the decoded fields (`dec_valid`, significands, unbiased exponents, class and special flags) to the divider core. All fields are held stable until the divider pulses `div_ready` on completion.

## Interface
- `OPERAND_WIDTH`, 32, IEEE word width
- `FRACTION_WIDTH`, 23, stored fraction bits
- `SIGNIFICAND_WIDTH`, 24, fraction plus hidden bit
- `UNB_EXP_WIDTH`, 10, two's-complement unbiased exponent width
- `BIASING_CONSTANT`, 127, exponent bias
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable; low freezes FSM and all registers
- `op_valid`  in  1  operand pair valid
- `op_ready`  out  1  decoder can accept; combinational, `(state==IDLE) & en`
- `op1`, `op2`  in  32 each  dividend, divisor
- `div_ready`  in  1  one-cycle completion pulse from divider
- `dec_valid`  out  1  decoded fields valid and stable
- `sign1`, `sign2`  out  1 each  operand signs
- `sgfnd1`, `sgfnd2`  out  24 each  significands; bit 23 set for finite nonzero after decode
- `unb_exp1`, `unb_exp2`  out  `UNB_EXP_WIDTH` each  signed unbiased exponents
- `is_norm1/2`, `is_denorm1/2`  out  1 each  input class (pre-normalization)
- `res_nan`  out  32  quieted NaN result word, 0 if none
- `res_indet`, `res_inf`, `res_zero`  out  1 each  special-result flags

## Operation
- States: IDLE, CLASSIFY, NORM, PRESENT.
- IDLE: on `op_valid & op_ready`, register `op1`/`op2` and go to CLASSIFY.
- CLASSIFY (1 cycle): register the following.
  - Signs, class bits and significands.
    - Normal: `{1,frac}`, exp `e-127`.
    - Denormal: `{0,frac}`, exp `-126`.
    - Zero/inf/NaN: significand 0, exp 0.
  - `res_nan`: op1 NaN gives op1 with bit 22 forced 1; else op2 NaN gives op2 quieted; else 0.
  - `res_indet`: 0/0 or inf/inf, with no NaN input.
  - `res_inf`: inf/finite, or finite-nonzero/0, with no NaN or indet.
  - `res_zero`: 0/finite-nonzero, or finite/inf, with no NaN or indet.
  - Transition: go to NORM if any finite nonzero operand has significand bit 23 = 0; else go to PRESENT.
- NORM: each cycle, every significand with bit23=0 and nonzero is shifted left 1 and its exponent is decremented by 1. A 5-bit counter bounds the loop. Exit to PRESENT when all nonzero significands have bit23=1; exit is forced at count 23.
- PRESENT: `dec_valid`=1, with all fields held. On `div_ready`, go to IDLE; `dec_valid` is 0 on the following cycle.
- `div_ready` outside PRESENT is ignored.
- `en`=0 in any state holds state and all registers.
- `rst` in any state (including NORM/PRESENT) forces IDLE. Outputs clear at that edge.

## Timing
- Reset value of every registered output is 0. `op_ready` equals `en` after reset.
- Accept at edge N. CLASSIFY occupies N..N+1. `dec_valid` rises at edge N+2 for normal/special operands.
- Denormal latency is N+2+k, where k = max leading-zero shifts across both operands (1..23).
- Back-to-back: the next pair is accepted no earlier than the cycle after `dec_valid` falls.
- Minimum 3-cycle accept interval plus divider latency.
- Exponent range: min -149, max +127; fits `UNB_EXP_WIDTH`=10 signed.

## Configuration
- `FFDIV_DAZ_EN` defined: denormals-are-zero.
  - Denormal inputs are classified as zero: `is_denorm`=0, significand/exp 0.
  - Special flags are computed accordingly.
  - NORM is never entered; latency is always 2.
- Undefined: full denormal normalization as above.

## Test plan
- op1=0x40C00000, op2=0x40000000 -> `dec_valid` at accept+2.
  - Expected: sgfnd1=0xC00000, unb_exp1=2, sgfnd2=0x800000, unb_exp2=1, all special flags 0.
- op1=0x00000001, op2=0x3F800000 -> 23 NORM cycles, `dec_valid` at accept+25.
  - Expected: sgfnd1=0x800000, unb_exp1=-149, is_denorm1=1.
  - With `FFDIV_DAZ_EN`: accept+2, res_zero=1.
- op1=0x7F800001, op2=0x40000000 -> res_nan=0x7FC00001, res_indet/res_inf/res_zero=0.
- op1=0x00000000, op2=0x80000000 -> res_indet=1.
- op1=0x3F800000, op2=0x00000000 -> res_inf=1, sgfnd2=0.
  - Hold `div_ready` low 10 cycles: fields stable. Pulse it: `dec_valid` 0 next cycle, `op_ready`=1.
- op1=0x00400000 with `rst` asserted during NORM -> all outputs 0 next edge, state IDLE.
  - Re-issue: unb_exp1=-127 after 1 NORM cycle.

Source files
------------

// File: rtl/ffdiv_operand_decode.sv
// ffdiv_operand_decode: FP32 divider operand classifier/normalizer; define FFDIV_DAZ_EN to treat denormals as zero
module ffdiv_operand_decode #(
    parameter int OPERAND_WIDTH     = 32,
    parameter int FRACTION_WIDTH    = 23,
    parameter int SIGNIFICAND_WIDTH = 24,
    parameter int UNB_EXP_WIDTH     = 10,
    parameter int BIASING_CONSTANT  = 127
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [OPERAND_WIDTH-1:0]     op1,
    input  logic [OPERAND_WIDTH-1:0]     op2,
    input  logic                         div_ready,
    output logic                         dec_valid,
    output logic                         sign1,
    output logic                         sign2,
    output logic [SIGNIFICAND_WIDTH-1:0] sgfnd1,
    output logic [SIGNIFICAND_WIDTH-1:0] sgfnd2,
    output logic [UNB_EXP_WIDTH-1:0]     unb_exp1,
    output logic [UNB_EXP_WIDTH-1:0]     unb_exp2,
    output logic                         is_norm1,
    output logic                         is_norm2,
    output logic                         is_denorm1,
    output logic                         is_denorm2,
    output logic [OPERAND_WIDTH-1:0]     res_nan,
    output logic                         res_indet,
    output logic                         res_inf,
    output logic                         res_zero
);
    localparam int EW = OPERAND_WIDTH - FRACTION_WIDTH - 1;
    localparam int SW = SIGNIFICAND_WIDTH;
    localparam int UW = UNB_EXP_WIDTH;

    typedef enum logic [1:0] {IDLE, CLASSIFY, NORM, PRESENT} state_t;
    state_t state, next;

    logic [OPERAND_WIDTH-1:0] op_r [2];
    logic [SW-1:0] sg [2];
    logic [UW-1:0] ex [2];
    logic [SW-1:0] cls_sg [2];
    logic [SW-1:0] nrm_sg [2];
    logic [UW-1:0] cls_ex [2];
    logic [UW-1:0] nrm_ex [2];
    logic [1:0] nan, inf, zero, den, norm, fin, fnz, shift, nrm_done;
    logic [4:0] cnt;
    logic any_nan, indet;

    for (genvar i = 0; i < 2; i++) begin : g_op
        logic [EW-1:0] e;
        logic [FRACTION_WIDTH-1:0] f;
        assign e = op_r[i][OPERAND_WIDTH-2 -: EW];
        assign f = op_r[i][FRACTION_WIDTH-1:0];
        assign nan[i]  = &e & |f;
        assign inf[i]  = &e & ~|f;
        assign norm[i] = |e & ~&e;
`ifdef FFDIV_DAZ_EN
        assign den[i]  = 1'b0;
        assign zero[i] = ~|e;
`else
        assign den[i]  = ~|e & |f;
        assign zero[i] = ~|e & ~|f;
`endif
        assign fin[i] = ~nan[i] & ~inf[i];
        assign fnz[i] = norm[i] | den[i];
        assign cls_sg[i] = norm[i] ? {1'b1, f} : den[i] ? {1'b0, f} : '0;
        assign cls_ex[i] = norm[i] ? UW'(e) - UW'(BIASING_CONSTANT) : den[i] ? UW'(1 - BIASING_CONSTANT) : '0;
        // Zeros never shift; a nonzero significand moves up until the hidden bit is set
        assign shift[i] = |sg[i] & ~sg[i][SW-1];
        assign nrm_sg[i] = shift[i] ? sg[i] << 1 : sg[i];
        assign nrm_ex[i] = shift[i] ? ex[i] - UW'(1) : ex[i];
        assign nrm_done[i] = ~|nrm_sg[i] | nrm_sg[i][SW-1];
    end

    assign any_nan = |nan;
    assign indet = ~any_nan & ((zero[0] & zero[1]) | (inf[0] & inf[1]));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (en)
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = op_valid ? CLASSIFY : IDLE;
            CLASSIFY: next = |den ? NORM : PRESENT;
            NORM:     next = (&nrm_done || cnt == 5'd22) ? PRESENT : NORM;
            PRESENT:  next = (div_ready && dec_valid) ? IDLE : PRESENT;
            default:  next = IDLE;
        endcase
    end

    always_comb op_ready = (state == IDLE) & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= '{default: '0};
            sg         <= '{default: '0};
            ex         <= '{default: '0};
            cnt        <= '0;
            dec_valid  <= 1'b0;
            sign1      <= 1'b0;
            sign2      <= 1'b0;
            is_norm1   <= 1'b0;
            is_norm2   <= 1'b0;
            is_denorm1 <= 1'b0;
            is_denorm2 <= 1'b0;
            res_nan    <= '0;
            res_indet  <= 1'b0;
            res_inf    <= 1'b0;
            res_zero   <= 1'b0;
        end else if (en) begin
            if (state == IDLE && op_valid) begin
                op_r[0] <= op1;
                op_r[1] <= op2;
            end
            if (state == CLASSIFY) begin
                sg         <= cls_sg;
                ex         <= cls_ex;
                cnt        <= '0;
                sign1      <= op_r[0][OPERAND_WIDTH-1];
                sign2      <= op_r[1][OPERAND_WIDTH-1];
                is_norm1   <= norm[0];
                is_norm2   <= norm[1];
                is_denorm1 <= den[0];
                is_denorm2 <= den[1];
                res_nan    <= nan[0] ? op_r[0] | OPERAND_WIDTH'(1) << (FRACTION_WIDTH - 1) :
                              nan[1] ? op_r[1] | OPERAND_WIDTH'(1) << (FRACTION_WIDTH - 1) : '0;
                res_indet  <= indet;
                res_inf    <= ~any_nan & ~indet & ((inf[0] & fin[1]) | (fnz[0] & zero[1]));
                res_zero   <= ~any_nan & ~indet & ((zero[0] & fnz[1]) | (fin[0] & inf[1]));
            end
            if (state == NORM) begin
                sg  <= nrm_sg;
                ex  <= nrm_ex;
                cnt <= cnt + 5'd1;
            end
            // Valid trails the PRESENT state by one edge and drops with the completion pulse
            dec_valid <= state == PRESENT && !(div_ready && dec_valid);
        end
    end

    assign sgfnd1   = sg[0];
    assign sgfnd2   = sg[1];
    assign unb_exp1 = ex[0];
    assign unb_exp2 = ex[1];
endmodule

// File: tb/tb_ffdiv_operand_decode.sv
// tb_ffdiv_operand_decode: directed-vector bench for ffdiv_operand_decode (honours FFDIV_DAZ_EN)
module tb_ffdiv_operand_decode;
    logic        clk = 0, rst = 1, en = 1, op_valid = 0, div_ready = 0;
    logic [31:0] op1 = 0, op2 = 0;
    logic        op_ready, dec_valid, sign1, sign2;
    logic [23:0] sgfnd1, sgfnd2;
    logic [9:0]  unb_exp1, unb_exp2;
    logic        is_norm1, is_norm2, is_denorm1, is_denorm2;
    logic [31:0] res_nan;
    logic        res_indet, res_inf, res_zero;
    int errors = 0, checks = 0, lat;
    logic stable;

    ffdiv_operand_decode dut (
        .clk(clk), .rst(rst), .en(en), .op_valid(op_valid), .op_ready(op_ready),
        .op1(op1), .op2(op2), .div_ready(div_ready), .dec_valid(dec_valid),
        .sign1(sign1), .sign2(sign2), .sgfnd1(sgfnd1), .sgfnd2(sgfnd2),
        .unb_exp1(unb_exp1), .unb_exp2(unb_exp2), .is_norm1(is_norm1), .is_norm2(is_norm2),
        .is_denorm1(is_denorm1), .is_denorm2(is_denorm2), .res_nan(res_nan),
        .res_indet(res_indet), .res_inf(res_inf), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int k);
        @(negedge clk);
        op1 = a;
        op2 = b;
        op_valid = 1;
        check("op_ready_before_accept", op_ready, 1);
        @(negedge clk);
        op_valid = 0;
        k = 0;
        while (!dec_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic release_dec;
        div_ready = 1;
        @(negedge clk);
        div_ready = 0;
        check("dec_valid_after_div_ready", dec_valid, 0);
        check("op_ready_after_div_ready", op_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_dec_valid", dec_valid, 0);
        check("rst_sgfnd1", sgfnd1, 0);
        check("rst_res_nan", res_nan, 0);
        check("rst_op_ready", op_ready, 1);

        send(32'h40C00000, 32'h40000000, lat);
        check("t1_latency", lat, 2);
        check("t1_sgfnd1", sgfnd1, 24'hC00000);
        check("t1_exp1", $signed(unb_exp1), 2);
        check("t1_sgfnd2", sgfnd2, 24'h800000);
        check("t1_exp2", $signed(unb_exp2), 1);
        check("t1_is_norm1", is_norm1, 1);
        check("t1_flags", {res_nan != 0, res_indet, res_inf, res_zero}, 0);
        release_dec();

        send(32'h00000001, 32'h3F800000, lat);
`ifdef FFDIV_DAZ_EN
        check("t2_latency", lat, 2);
        check("t2_sgfnd1", sgfnd1, 0);
        check("t2_is_denorm1", is_denorm1, 0);
        check("t2_res_zero", res_zero, 1);
`else
        check("t2_latency", lat, 25);
        check("t2_sgfnd1", sgfnd1, 24'h800000);
        check("t2_exp1", $signed(unb_exp1), -149);
        check("t2_is_denorm1", is_denorm1, 1);
        check("t2_res_zero", res_zero, 0);
`endif
        check("t2_sgfnd2", sgfnd2, 24'h800000);
        check("t2_exp2", $signed(unb_exp2), 0);
        release_dec();

        send(32'h7F800001, 32'h40000000, lat);
        check("t3_latency", lat, 2);
        check("t3_res_nan", res_nan, 32'h7FC00001);
        check("t3_flags", {res_indet, res_inf, res_zero}, 0);
        release_dec();

        send(32'h3F800000, 32'hFF800005, lat);
        check("t3b_res_nan_op2", res_nan, 32'hFFC00005);
        check("t3b_sign2", sign2, 1);
        release_dec();

        send(32'h00000000, 32'h80000000, lat);
        check("t4_res_indet", res_indet, 1);
        check("t4_sign2", sign2, 1);
        check("t4_res_inf", res_inf, 0);
        release_dec();

        send(32'h7F800000, 32'hFF800000, lat);
        check("t4b_inf_inf_indet", res_indet, 1);
        release_dec();

        send(32'h3F800000, 32'h7F800000, lat);
        check("t4c_finite_over_inf_zero", res_zero, 1);
        check("t4c_res_inf", res_inf, 0);
        release_dec();

        send(32'h3F800000, 32'h00000000, lat);
        check("t5_res_inf", res_inf, 1);
        check("t5_sgfnd2", sgfnd2, 0);
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (dec_valid !== 1 || res_inf !== 1 || sgfnd1 !== 24'h800000 || sgfnd2 !== 0) stable = 0;
        end
        check("t5_hold_stable", stable, 1);
        en = 0;
        div_ready = 1;
        @(negedge clk);
        div_ready = 0;
        en = 1;
        check("t5_en_low_ignores_div_ready", dec_valid, 1);
        check("t5_op_ready_in_present", op_ready, 0);
        release_dec();

        @(negedge clk);
        op1 = 32'h00400000;
        op2 = 32'h3F800000;
        op_valid = 1;
        @(negedge clk);
        op_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t6_rst_dec_valid", dec_valid, 0);
        check("t6_rst_sgfnd1", sgfnd1, 0);
        check("t6_rst_exp1", unb_exp1, 0);
        check("t6_rst_is_denorm1", is_denorm1, 0);
        check("t6_rst_op_ready", op_ready, 1);

        send(32'h00400000, 32'h3F800000, lat);
`ifdef FFDIV_DAZ_EN
        check("t6_latency", lat, 2);
        check("t6_exp1", $signed(unb_exp1), 0);
        check("t6_sgfnd1", sgfnd1, 0);
`else
        check("t6_latency", lat, 3);
        check("t6_exp1", $signed(unb_exp1), -127);
        check("t6_sgfnd1", sgfnd1, 24'h800000);
`endif
        release_dec();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
